cdb_arbiter: RTL and testbench

CDB_ARBITER -- requirements
Module: cdb_arbiter

---
 rtl/cdb_arbiter_pkg.sv | 20 ++
 rtl/cdb_src_fifo.sv | 80 ++++++++
 rtl/cdb_arbiter.sv | 136 +++++++++++++
 tb/tb_cdb_arbiter.sv | 446 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cdb_arbiter_pkg.sv
// Shared definitions for the common-data-bus arbiter: source codes,
// default tag width and the round-robin pointer helper.
package cdb_arbiter_pkg;

    localparam int ROB_ID_W_DEF = 4;
    localparam int NUM_SRC      = 3;
    localparam int VALUE_W      = 32;

    typedef logic [1:0] src_t;

    localparam src_t SRC_ALU = 2'd0;
    localparam src_t SRC_LSB = 2'd1;
    localparam src_t SRC_BR  = 2'd2;

    // Next source in round-robin order, wrapping BR back to ALU.
    function automatic src_t src_next(input src_t s);
        return (s == SRC_BR) ? SRC_ALU : src_t'(s + 2'd1);
    endfunction

endpackage

// File: rtl/cdb_src_fifo.sv
// Per-source result queue: {rob_id, value} entries, pointers and count.
// Frozen while run=0; emptied on a running clr. Full is reported from the
// current count only, so a same-edge pop never frees a slot for a push.
module cdb_src_fifo
    import cdb_arbiter_pkg::*;
#(
    parameter int ROB_ID_W = ROB_ID_W_DEF,
    parameter int QDEPTH   = 2
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                run,
    input  logic                clr,
    input  logic                push,
    input  logic [ROB_ID_W-1:0] push_rob_id,
    input  logic [VALUE_W-1:0]  push_value,
    input  logic                pop,
    output logic                full,
    output logic                empty,
    output logic [ROB_ID_W-1:0] head_rob_id,
    output logic [VALUE_W-1:0]  head_value
);

    localparam int PTR_W = $clog2(QDEPTH);
    localparam int CNT_W = $clog2(QDEPTH + 1);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(QDEPTH);

    logic [PTR_W-1:0]    wr_ptr;
    logic [PTR_W-1:0]    rd_ptr;
    logic [CNT_W-1:0]    count;
    logic [ROB_ID_W-1:0] mem_rob_id [QDEPTH];
    logic [VALUE_W-1:0]  mem_value  [QDEPTH];
    logic                do_push;
    logic                do_pop;

    assign full  = (count == CNT_FULL);
    assign empty = (count == '0);

    assign do_push = run & ~clr & push & ~full;
    assign do_pop  = run & ~clr & pop & ~empty;

    assign head_rob_id = mem_rob_id[rd_ptr];
    assign head_value  = mem_value[rd_ptr];

    // Pointer and occupancy tracking; pointers wrap naturally (power-of-two depth).
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (run) begin
            if (clr) begin
                wr_ptr <= '0;
                rd_ptr <= '0;
                count  <= '0;
            end else begin
                if (do_push) begin
                    wr_ptr <= wr_ptr + PTR_W'(1);
                end
                if (do_pop) begin
                    rd_ptr <= rd_ptr + PTR_W'(1);
                end
                case ({do_push, do_pop})
                    2'b10:   count <= count + CNT_W'(1);
                    2'b01:   count <= count - CNT_W'(1);
                    default: count <= count;
                endcase
            end
        end
    end

    // Entry storage; contents are only meaningful behind the pointers, so no reset.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_rob_id[wr_ptr] <= push_rob_id;
            mem_value[wr_ptr]  <= push_value;
        end
    end

endmodule

// File: rtl/cdb_arbiter.sv
// Common-data-bus arbiter: queues results from ALU, LSB and branch units,
// picks one non-empty queue per cycle round-robin and registers its head
// onto the broadcast bus. No bypass: a result accepted at one edge is
// broadcast at the earliest after the following edge.
module cdb_arbiter
    import cdb_arbiter_pkg::*;
#(
    parameter int ROB_ID_W = ROB_ID_W_DEF,
    parameter int QDEPTH   = 2
) (
    input  logic                clk_in,
    input  logic                rst_in,
    input  logic                rdy_in,
    input  logic                flush_pipline,

    input  logic                alu_valid,
    input  logic [ROB_ID_W-1:0] alu_rob_id,
    input  logic [VALUE_W-1:0]  alu_value,
    output logic                alu_ready,

    input  logic                lsb_valid,
    input  logic [ROB_ID_W-1:0] lsb_rob_id,
    input  logic [VALUE_W-1:0]  lsb_value,
    output logic                lsb_ready,

    input  logic                br_valid,
    input  logic [ROB_ID_W-1:0] br_rob_id,
    input  logic [VALUE_W-1:0]  br_value,
    output logic                br_ready,

    output logic                cdb_valid,
    output logic [ROB_ID_W-1:0] cdb_rob_id,
    output logic [VALUE_W-1:0]  cdb_value,
    output logic [1:0]          cdb_src
);

    logic [NUM_SRC-1:0]  src_valid;
    logic [NUM_SRC-1:0]  src_ready;
    logic [NUM_SRC-1:0]  q_full;
    logic [NUM_SRC-1:0]  q_empty;
    logic [NUM_SRC-1:0]  q_pop;
    logic [ROB_ID_W-1:0] src_rob_id  [NUM_SRC];
    logic [VALUE_W-1:0]  src_value   [NUM_SRC];
    logic [ROB_ID_W-1:0] head_rob_id [NUM_SRC];
    logic [VALUE_W-1:0]  head_value  [NUM_SRC];
    logic                accept_en;
    logic                sel_valid;
    src_t                sel;
    src_t                cand;
    src_t                rr;

    assign src_valid = {br_valid, lsb_valid, alu_valid};

    assign src_rob_id[SRC_ALU] = alu_rob_id;
    assign src_rob_id[SRC_LSB] = lsb_rob_id;
    assign src_rob_id[SRC_BR]  = br_rob_id;
    assign src_value[SRC_ALU]  = alu_value;
    assign src_value[SRC_LSB]  = lsb_value;
    assign src_value[SRC_BR]   = br_value;

    // Ready is held low during reset, pause and flush, and whenever the queue
    // is full (even if it is being drained this same edge).
    assign accept_en = rst_in & rdy_in & ~flush_pipline;
    assign src_ready = {NUM_SRC{accept_en}} & ~q_full;

    assign alu_ready = src_ready[SRC_ALU];
    assign lsb_ready = src_ready[SRC_LSB];
    assign br_ready  = src_ready[SRC_BR];

    for (genvar i = 0; i < NUM_SRC; i++) begin : g_src
        cdb_src_fifo #(
            .ROB_ID_W (ROB_ID_W),
            .QDEPTH   (QDEPTH)
        ) u_fifo (
            .clk         (clk_in),
            .rst_n       (rst_in),
            .run         (rdy_in),
            .clr         (flush_pipline),
            .push        (src_valid[i] & src_ready[i]),
            .push_rob_id (src_rob_id[i]),
            .push_value  (src_value[i]),
            .pop         (q_pop[i]),
            .full        (q_full[i]),
            .empty       (q_empty[i]),
            .head_rob_id (head_rob_id[i]),
            .head_value  (head_value[i])
        );
    end

    // Round-robin search over rr, rr+1, rr+2 for the first non-empty queue.
    always_comb begin
        sel_valid = 1'b0;
        sel       = rr;
        cand      = rr;
        for (int k = 0; k < NUM_SRC; k++) begin
            if (!sel_valid && !q_empty[cand]) begin
                sel_valid = 1'b1;
                sel       = cand;
            end
            cand = src_next(cand);
        end
    end

    // Pop the granted queue only on a running, non-flushing edge.
    always_comb begin
        q_pop = '0;
        if (rdy_in && !flush_pipline && sel_valid) begin
            q_pop[sel] = 1'b1;
        end
    end

    // Broadcast register and round-robin pointer; everything freezes while paused.
    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            cdb_valid  <= 1'b0;
            cdb_rob_id <= '0;
            cdb_value  <= '0;
            cdb_src    <= SRC_ALU;
            rr         <= SRC_ALU;
        end else if (rdy_in) begin
            if (flush_pipline) begin
                cdb_valid <= 1'b0;
                rr        <= SRC_ALU;
            end else if (sel_valid) begin
                cdb_valid  <= 1'b1;
                cdb_rob_id <= head_rob_id[sel];
                cdb_value  <= head_value[sel];
                cdb_src    <= sel;
                rr         <= src_next(sel);
            end else begin
                cdb_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_cdb_arbiter.sv
// Bench for cdb_arbiter: directed scenarios with a queue of expected
// broadcast beats, popped as the bus produces them.
module tb_cdb_arbiter;

    localparam int ROB_ID_W = 4;
    localparam int QDEPTH   = 2;

    typedef struct packed {
        logic [1:0]          src;
        logic [ROB_ID_W-1:0] rob_id;
        logic [31:0]         value;
    } beat_t;

    logic                clk_in = 1'b0;
    logic                rst_in;
    logic                rdy_in;
    logic                flush_pipline;
    logic                alu_valid, lsb_valid, br_valid;
    logic [ROB_ID_W-1:0] alu_rob_id, lsb_rob_id, br_rob_id;
    logic [31:0]         alu_value, lsb_value, br_value;
    logic                alu_ready, lsb_ready, br_ready;
    logic                cdb_valid;
    logic [ROB_ID_W-1:0] cdb_rob_id;
    logic [31:0]         cdb_value;
    logic [1:0]          cdb_src;

    int    checks = 0;
    int    errors = 0;
    beat_t exp_q[$];
    beat_t exp_b;

    cdb_arbiter #(
        .ROB_ID_W (ROB_ID_W),
        .QDEPTH   (QDEPTH)
    ) dut (
        .clk_in        (clk_in),
        .rst_in        (rst_in),
        .rdy_in        (rdy_in),
        .flush_pipline (flush_pipline),
        .alu_valid     (alu_valid),
        .alu_rob_id    (alu_rob_id),
        .alu_value     (alu_value),
        .alu_ready     (alu_ready),
        .lsb_valid     (lsb_valid),
        .lsb_rob_id    (lsb_rob_id),
        .lsb_value     (lsb_value),
        .lsb_ready     (lsb_ready),
        .br_valid      (br_valid),
        .br_rob_id     (br_rob_id),
        .br_value      (br_value),
        .br_ready      (br_ready),
        .cdb_valid     (cdb_valid),
        .cdb_rob_id    (cdb_rob_id),
        .cdb_value     (cdb_value),
        .cdb_src       (cdb_src)
    );

    always #5 clk_in = ~clk_in;

    function automatic beat_t mk_beat(input logic [1:0] s, input logic [ROB_ID_W-1:0] id,
                                      input logic [31:0] v);
        beat_t b;
        b.src    = s;
        b.rob_id = id;
        b.value  = v;
        return b;
    endfunction

    task automatic clear_inputs();
        rdy_in        = 1'b1;
        flush_pipline = 1'b0;
        alu_valid     = 1'b0;
        lsb_valid     = 1'b0;
        br_valid      = 1'b0;
        alu_rob_id    = '0;
        lsb_rob_id    = '0;
        br_rob_id     = '0;
        alu_value     = '0;
        lsb_value     = '0;
        br_value      = '0;
    endtask

    task automatic drive_all(input logic [ROB_ID_W-1:0] ia, input logic [31:0] va,
                             input logic [ROB_ID_W-1:0] il, input logic [31:0] vl,
                             input logic [ROB_ID_W-1:0] ib, input logic [31:0] vb);
        alu_valid = 1'b1; alu_rob_id = ia; alu_value = va;
        lsb_valid = 1'b1; lsb_rob_id = il; lsb_value = vl;
        br_valid  = 1'b1; br_rob_id  = ib; br_value  = vb;
    endtask

    task automatic do_reset();
        clear_inputs();
        rst_in = 1'b0;
        exp_q.delete();
        @(posedge clk_in);
        @(negedge clk_in);
        rst_in = 1'b1;
    endtask

    task automatic test_reset();
        clear_inputs();
        rst_in = 1'b0;
        alu_valid = 1'b1;
        lsb_valid = 1'b1;
        br_valid  = 1'b1;
        #2;
        checks++;
        if ({cdb_valid, cdb_src, cdb_rob_id, cdb_value} !== '0) begin
            errors++;
            $display("FAIL reset_outputs: got v=%b src=%0d id=%0d val=%h, expected all 0",
                     cdb_valid, cdb_src, cdb_rob_id, cdb_value);
        end
        checks++;
        if ({alu_ready, lsb_ready, br_ready} !== 3'b000) begin
            errors++;
            $display("FAIL reset_ready: got %b, expected 000", {alu_ready, lsb_ready, br_ready});
        end
        do_reset();
    endtask

    task automatic test_single_alu();
        do_reset();
        @(negedge clk_in);
        alu_valid = 1'b1; alu_rob_id = 4'd3; alu_value = 32'hDEADBEEF;
        #1;
        checks++;
        if (alu_ready !== 1'b1) begin
            errors++;
            $display("FAIL single_ready: got %b, expected 1", alu_ready);
        end
        @(posedge clk_in); #1;
        checks++;
        if (cdb_valid !== 1'b0) begin
            errors++;
            $display("FAIL single_no_bypass: cdb_valid got %b, expected 0", cdb_valid);
        end
        @(negedge clk_in);
        alu_valid = 1'b0;
        @(posedge clk_in); #1;
        checks++;
        if ({cdb_valid, cdb_src, cdb_rob_id, cdb_value} !== {1'b1, 2'd0, 4'd3, 32'hDEADBEEF}) begin
            errors++;
            $display("FAIL single_beat: got v=%b src=%0d id=%0d val=%h, expected v=1 src=0 id=3 val=deadbeef",
                     cdb_valid, cdb_src, cdb_rob_id, cdb_value);
        end
        @(posedge clk_in); #1;
        checks++;
        if (cdb_valid !== 1'b0) begin
            errors++;
            $display("FAIL single_one_cycle: cdb_valid got %b, expected 0", cdb_valid);
        end
    endtask

    task automatic test_round_robin();
        logic [31:0] vals [3];
        vals[0] = 32'h1111_1111;
        vals[1] = 32'h2222_2222;
        vals[2] = 32'h3333_3333;
        do_reset();
        for (int k = 0; k < 6; k++) begin
            exp_q.push_back(mk_beat(2'(k % 3), 4'(k % 3 + 1), vals[k % 3]));
        end
        for (int c = 0; c < 7; c++) begin
            @(negedge clk_in);
            drive_all(4'd1, vals[0], 4'd2, vals[1], 4'd3, vals[2]);
            #1;
            if (c == 2) begin
                checks++;
                if ({alu_ready, lsb_ready, br_ready} !== 3'b100) begin
                    errors++;
                    $display("FAIL rr_ready_full: got %b, expected 100", {alu_ready, lsb_ready, br_ready});
                end
            end
            @(posedge clk_in); #1;
            if (c >= 1) begin
                checks++;
                if (cdb_valid !== 1'b1) begin
                    errors++;
                    $display("FAIL rr_no_idle: cycle %0d cdb_valid got %b, expected 1", c, cdb_valid);
                end
            end
            if (cdb_valid === 1'b1) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL rr_beat: unexpected beat src=%0d id=%0d, expected none", cdb_src, cdb_rob_id);
                end else begin
                    exp_b = exp_q.pop_front();
                    if ({cdb_src, cdb_rob_id, cdb_value} !== exp_b) begin
                        errors++;
                        $display("FAIL rr_beat: got src=%0d id=%0d val=%h, expected src=%0d id=%0d val=%h",
                                 cdb_src, cdb_rob_id, cdb_value, exp_b.src, exp_b.rob_id, exp_b.value);
                    end
                end
            end
        end
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL rr_missing: %0d beats never seen, expected 0", exp_q.size());
        end
        do_reset();
    endtask

    task automatic test_lsb_full();
        logic exp_rdy;
        do_reset();
        exp_q.push_back(mk_beat(2'd0, 4'd7,  32'hA0A0_0000));
        exp_q.push_back(mk_beat(2'd1, 4'd8,  32'h1000_0000));
        exp_q.push_back(mk_beat(2'd1, 4'd9,  32'h1000_0001));
        exp_q.push_back(mk_beat(2'd1, 4'd10, 32'h1000_0002));
        exp_q.push_back(mk_beat(2'd1, 4'd11, 32'h1000_0003));
        for (int c = 0; c < 8; c++) begin
            @(negedge clk_in);
            clear_inputs();
            case (c)
                0: begin
                    alu_valid = 1'b1; alu_rob_id = 4'd7; alu_value = 32'hA0A0_0000;
                    lsb_valid = 1'b1; lsb_rob_id = 4'd8; lsb_value = 32'h1000_0000;
                end
                1: begin lsb_valid = 1'b1; lsb_rob_id = 4'd9;  lsb_value = 32'h1000_0001; end
                2, 3: begin lsb_valid = 1'b1; lsb_rob_id = 4'd10; lsb_value = 32'h1000_0002; end
                4: begin lsb_valid = 1'b1; lsb_rob_id = 4'd11; lsb_value = 32'h1000_0003; end
                default: ;
            endcase
            #1;
            if (c <= 4) begin
                exp_rdy = (c == 2) ? 1'b0 : 1'b1;
                checks++;
                if (lsb_ready !== exp_rdy) begin
                    errors++;
                    $display("FAIL lsb_ready: cycle %0d got %b, expected %b", c, lsb_ready, exp_rdy);
                end
            end
            @(posedge clk_in); #1;
            if (cdb_valid === 1'b1) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL lsb_beat: unexpected beat src=%0d id=%0d, expected none", cdb_src, cdb_rob_id);
                end else begin
                    exp_b = exp_q.pop_front();
                    if ({cdb_src, cdb_rob_id, cdb_value} !== exp_b) begin
                        errors++;
                        $display("FAIL lsb_beat: got src=%0d id=%0d val=%h, expected src=%0d id=%0d val=%h",
                                 cdb_src, cdb_rob_id, cdb_value, exp_b.src, exp_b.rob_id, exp_b.value);
                    end
                end
            end
        end
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL lsb_missing: %0d beats never seen, expected 0", exp_q.size());
        end
    endtask

    task automatic test_flush();
        do_reset();
        exp_q.push_back(mk_beat(2'd0, 4'd1, 32'hC000_0000));
        exp_q.push_back(mk_beat(2'd1, 4'd2, 32'hC100_0000));
        exp_q.push_back(mk_beat(2'd0, 4'd7, 32'hD000_0000));
        exp_q.push_back(mk_beat(2'd1, 4'd8, 32'hD100_0000));
        exp_q.push_back(mk_beat(2'd2, 4'd9, 32'hD200_0000));
        for (int c = 0; c < 10; c++) begin
            @(negedge clk_in);
            clear_inputs();
            case (c)
                0: drive_all(4'd1, 32'hC000_0000, 4'd2, 32'hC100_0000, 4'd3, 32'hC200_0000);
                1: begin alu_valid = 1'b1; alu_rob_id = 4'd4; alu_value = 32'hC000_0001; end
                2: begin alu_valid = 1'b1; alu_rob_id = 4'd5; alu_value = 32'hC000_0002; end
                3: begin
                    flush_pipline = 1'b1;
                    br_valid = 1'b1; br_rob_id = 4'd6; br_value = 32'hC200_0001;
                end
                5: drive_all(4'd7, 32'hD000_0000, 4'd8, 32'hD100_0000, 4'd9, 32'hD200_0000);
                default: ;
            endcase
            #1;
            if (c == 3) begin
                checks++;
                if ({alu_ready, lsb_ready, br_ready} !== 3'b000) begin
                    errors++;
                    $display("FAIL flush_ready: got %b, expected 000", {alu_ready, lsb_ready, br_ready});
                end
            end
            @(posedge clk_in); #1;
            if (c == 3 || c == 4) begin
                checks++;
                if (cdb_valid !== 1'b0) begin
                    errors++;
                    $display("FAIL flush_idle: cycle %0d cdb_valid got %b, expected 0", c, cdb_valid);
                end
            end
            if (c == 6) begin
                checks++;
                if ({cdb_valid, cdb_src} !== {1'b1, 2'd0}) begin
                    errors++;
                    $display("FAIL flush_rr: got v=%b src=%0d, expected v=1 src=0", cdb_valid, cdb_src);
                end
            end
            if (cdb_valid === 1'b1) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL flush_beat: unexpected beat src=%0d id=%0d, expected none", cdb_src, cdb_rob_id);
                end else begin
                    exp_b = exp_q.pop_front();
                    if ({cdb_src, cdb_rob_id, cdb_value} !== exp_b) begin
                        errors++;
                        $display("FAIL flush_beat: got src=%0d id=%0d val=%h, expected src=%0d id=%0d val=%h",
                                 cdb_src, cdb_rob_id, cdb_value, exp_b.src, exp_b.rob_id, exp_b.value);
                    end
                end
            end
        end
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL flush_missing: %0d beats never seen, expected 0", exp_q.size());
        end
    endtask

    task automatic test_pause();
        do_reset();
        @(negedge clk_in);
        alu_valid = 1'b1; alu_rob_id = 4'd5; alu_value = 32'h5555_0005;
        lsb_valid = 1'b1; lsb_rob_id = 4'd6; lsb_value = 32'h6666_0006;
        @(posedge clk_in); #1;
        @(negedge clk_in);
        clear_inputs();
        @(posedge clk_in); #1;
        checks++;
        if ({cdb_valid, cdb_src, cdb_rob_id, cdb_value} !== {1'b1, 2'd0, 4'd5, 32'h5555_0005}) begin
            errors++;
            $display("FAIL pause_setup: got v=%b src=%0d id=%0d val=%h, expected v=1 src=0 id=5 val=55550005",
                     cdb_valid, cdb_src, cdb_rob_id, cdb_value);
        end
        for (int c = 0; c < 3; c++) begin
            @(negedge clk_in);
            rdy_in = 1'b0;
            flush_pipline = 1'b1;
            alu_valid = 1'b1; alu_rob_id = 4'd12; alu_value = 32'hBAD0_000C;
            #1;
            checks++;
            if (alu_ready !== 1'b0) begin
                errors++;
                $display("FAIL pause_ready: cycle %0d got %b, expected 0", c, alu_ready);
            end
            @(posedge clk_in); #1;
            checks++;
            if ({cdb_valid, cdb_src, cdb_rob_id, cdb_value} !== {1'b1, 2'd0, 4'd5, 32'h5555_0005}) begin
                errors++;
                $display("FAIL pause_hold: cycle %0d got v=%b src=%0d id=%0d val=%h, expected v=1 src=0 id=5",
                         c, cdb_valid, cdb_src, cdb_rob_id, cdb_value);
            end
        end
        @(negedge clk_in);
        clear_inputs();
        @(posedge clk_in); #1;
        checks++;
        if ({cdb_valid, cdb_src, cdb_rob_id, cdb_value} !== {1'b1, 2'd1, 4'd6, 32'h6666_0006}) begin
            errors++;
            $display("FAIL pause_resume: got v=%b src=%0d id=%0d val=%h, expected v=1 src=1 id=6 val=66660006",
                     cdb_valid, cdb_src, cdb_rob_id, cdb_value);
        end
        @(posedge clk_in); #1;
        checks++;
        if (cdb_valid !== 1'b0) begin
            errors++;
            $display("FAIL pause_drain: cdb_valid got %b, expected 0", cdb_valid);
        end
    endtask

    task automatic test_reset_mid_burst();
        do_reset();
        exp_q.push_back(mk_beat(2'd0, 4'd1, 32'hE000_0001));
        for (int c = 0; c < 2; c++) begin
            @(negedge clk_in);
            drive_all(4'd1, 32'hE000_0001, 4'd2, 32'hE000_0002, 4'd3, 32'hE000_0003);
            @(posedge clk_in); #1;
            if (cdb_valid === 1'b1) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL rst_beat: unexpected beat src=%0d id=%0d, expected none", cdb_src, cdb_rob_id);
                end else begin
                    exp_b = exp_q.pop_front();
                    if ({cdb_src, cdb_rob_id, cdb_value} !== exp_b) begin
                        errors++;
                        $display("FAIL rst_beat: got src=%0d id=%0d val=%h, expected src=%0d id=%0d val=%h",
                                 cdb_src, cdb_rob_id, cdb_value, exp_b.src, exp_b.rob_id, exp_b.value);
                    end
                end
            end
        end
        @(negedge clk_in);
        #2;
        rst_in = 1'b0;
        #1;
        checks++;
        if ({cdb_valid, cdb_src, cdb_rob_id, cdb_value} !== '0) begin
            errors++;
            $display("FAIL rst_async_out: got v=%b src=%0d id=%0d val=%h, expected all 0",
                     cdb_valid, cdb_src, cdb_rob_id, cdb_value);
        end
        checks++;
        if ({alu_ready, lsb_ready, br_ready} !== 3'b000) begin
            errors++;
            $display("FAIL rst_async_ready: got %b, expected 000", {alu_ready, lsb_ready, br_ready});
        end
        @(negedge clk_in);
        clear_inputs();
        #2;
        rst_in = 1'b1;
        for (int c = 0; c < 5; c++) begin
            @(posedge clk_in); #1;
            checks++;
            if (cdb_valid !== 1'b0) begin
                errors++;
                $display("FAIL rst_discard: cycle %0d got beat src=%0d id=%0d, expected none",
                         c, cdb_src, cdb_rob_id);
            end
        end
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL rst_missing: %0d beats never seen, expected 0", exp_q.size());
        end
    endtask

    initial begin
        rst_in = 1'b0;
        clear_inputs();
        test_reset();
        test_single_alu();
        test_round_robin();
        test_lsb_full();
        test_flush();
        test_pause();
        test_reset_mid_burst();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
